// File: rtl/wifi_rx_pkg.sv
// Shared definitions for the WIFI receive BPSK demapper.
//   BPSK_SYM_BITS : coded bits per OFDM symbol (48 data subcarriers)
//   SOFT_W        : soft-decision width carried when WIFI_RX_SOFT_OUT_EN is defined
//   SOFT_SHIFT    : arithmetic right shift applied to the I sample before saturation
//   wr_state_e    : write-side frame FSM states
//   sat_soft()    : shift-and-saturate helper producing the soft value
package wifi_rx_pkg;

  localparam int unsigned BPSK_SYM_BITS = 48;
  localparam int unsigned SOFT_W        = 4;
  localparam int unsigned SOFT_SHIFT    = 7;

  typedef enum logic {
    StIdle,
    StRecv
  } wr_state_e;

  // Arithmetic shift then clamp into the signed SOFT_W range.
  function automatic logic signed [SOFT_W-1:0] sat_soft(input logic signed [11:0] x);
    logic signed [11:0] sh;
    sh = x >>> SOFT_SHIFT;
    if (sh > 12'sd7) begin
      return 4'sd7;
    end else if (sh < -12'sd8) begin
      return -4'sd8;
    end else begin
      return sh[SOFT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/wifi_rx_bpsk_demapper_if.sv
// Sample-in / bit-out bundle of the BPSK demapper.
//   master : upstream/downstream environment (drives samples and re)
//   slave  : demapper view
// soft_out exists only when WIFI_RX_SOFT_OUT_EN is defined.
interface wifi_rx_bpsk_demapper_if;
  import wifi_rx_pkg::*;

  logic               valid_in;
  logic signed [11:0] data_in_re;
  logic signed [11:0] data_in_im;
  logic               last_in;
  logic               re;
  logic               data_out;
  logic               valid_out;
  logic               last_sym;
  logic               finished;
  logic               full;
  logic               empty;
  logic               overflow;
  logic               misalign;
  logic               busy;
`ifdef WIFI_RX_SOFT_OUT_EN
  logic signed [SOFT_W-1:0] soft_out;

  modport master (
    output valid_in, data_in_re, data_in_im, last_in, re,
    input  data_out, valid_out, last_sym, finished, full, empty, overflow, misalign, busy,
           soft_out
  );

  modport slave (
    input  valid_in, data_in_re, data_in_im, last_in, re,
    output data_out, valid_out, last_sym, finished, full, empty, overflow, misalign, busy,
           soft_out
  );
`else
  modport master (
    output valid_in, data_in_re, data_in_im, last_in, re,
    input  data_out, valid_out, last_sym, finished, full, empty, overflow, misalign, busy
  );

  modport slave (
    input  valid_in, data_in_re, data_in_im, last_in, re,
    output data_out, valid_out, last_sym, finished, full, empty, overflow, misalign, busy
  );
`endif

endinterface

// File: rtl/wifi_rx_demap_fifo.sv
// Single-clock FIFO with a registered read port.
//   clk, reset        : clock, async active-low reset
//   wr_en, wr_data    : write request (dropped when full unless a read happens too)
//   rd_en             : read request (ignored when empty)
//   rd_data, rd_valid : registered read data, valid the cycle after an accepted read
//   full, empty       : registered status reflecting count after the current edge
//   count             : number of stored entries
module wifi_rx_demap_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             rd_do, wr_do;

  assign rd_do = rd_en & ~empty_q;
  // A full FIFO still takes a write when a read frees the slot on the same edge.
  assign wr_do = wr_en & (~full_q | rd_do);

  always_comb begin
    count_d = count_q;
    unique case ({wr_do, rd_do})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_do) wptr_q <= wptr_q + 1'b1;
      if (rd_do) begin
        rptr_q    <= rptr_q + 1'b1;
        rd_data_q <= mem[rptr_q];
      end
      rd_valid_q <= rd_do;
      count_q    <= count_d;
      full_q     <= (count_d == (AW+1)'(DEPTH));
      empty_q    <= (count_d == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_do) mem[wptr_q] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: rtl/wifi_rx_bpsk_demapper.sv
// Receive BPSK demapper: hard decision on the I sample, buffered in a FIFO and
// released bit-serially under the re handshake.
//   clk, reset : clock, async active-low reset
//   bus        : wifi_rx_bpsk_demapper_if.slave (samples in, bits/flags out)
// Optional feature macro WIFI_RX_SOFT_OUT_EN adds a 4-bit saturated soft value
// that travels through the FIFO alongside each decision.
module wifi_rx_bpsk_demapper
  import wifi_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned SYM_BITS   = BPSK_SYM_BITS
) (
  input logic                    clk,
  input logic                    reset,
  wifi_rx_bpsk_demapper_if.slave bus
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = (SYM_BITS > 1) ? $clog2(SYM_BITS) : 1;
  localparam logic [CntW-1:0] SymLast = CntW'(SYM_BITS - 1);
`ifdef WIFI_RX_SOFT_OUT_EN
  localparam int unsigned FifoW = 2 + SOFT_W;
`else
  localparam int unsigned FifoW = 2;
`endif

  // FIFO word layout: {last, bit[, soft]}
  logic [FifoW-1:0] wr_word, s1_data_q, rd_word;
  logic             s1_valid_q;
  logic             s1_last;
  logic             rd_acc, wr_acc;
  logic             fifo_full, fifo_empty, fifo_rd_valid;
  logic [AW:0]      fifo_count;
  wr_state_e        state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             overflow_q, misalign_q, finished_q;

`ifdef WIFI_RX_SOFT_OUT_EN
  assign wr_word = {bus.last_in, ~bus.data_in_re[11], sat_soft(bus.data_in_re)};
`else
  assign wr_word = {bus.last_in, ~bus.data_in_re[11]};
`endif

  assign s1_last = s1_data_q[FifoW-1];
  assign rd_acc  = bus.re & ~fifo_empty;
  assign wr_acc  = s1_valid_q & ((fifo_count < (AW+1)'(FIFO_DEPTH)) | rd_acc);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    // A new non-final sample wins over the previous frame's last write landing.
    if (bus.valid_in && !bus.last_in) begin
      state_d = StRecv;
    end else if (wr_acc && s1_last) begin
      state_d = StIdle;
    end
    if (wr_acc) begin
      if (s1_last || bit_cnt_q == SymLast) begin
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.valid_in;
      if (bus.valid_in) s1_data_q <= wr_word;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      overflow_q <= overflow_q | (s1_valid_q & ~wr_acc);
      misalign_q <= misalign_q | (wr_acc & s1_last & (bit_cnt_q != SymLast));
      finished_q <= fifo_rd_valid & rd_word[FifoW-1];
    end
  end

  wifi_rx_demap_fifo #(
    .WIDTH (FifoW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_acc),
    .wr_data  (s1_data_q),
    .rd_en    (rd_acc),
    .rd_data  (rd_word),
    .rd_valid (fifo_rd_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign bus.data_out  = rd_word[FifoW-2];
  assign bus.valid_out = fifo_rd_valid;
  assign bus.last_sym  = fifo_rd_valid & rd_word[FifoW-1];
  assign bus.finished  = finished_q;
  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.overflow  = overflow_q;
  assign bus.misalign  = misalign_q;
  assign bus.busy      = (state_q == StRecv) | ~fifo_empty | s1_valid_q;
`ifdef WIFI_RX_SOFT_OUT_EN
  assign bus.soft_out  = rd_word[SOFT_W-1:0];
`endif

endmodule

// File: tb/tb_wifi_rx_bpsk_demapper.sv
// Scoreboard bench for wifi_rx_bpsk_demapper (optionally with WIFI_RX_SOFT_OUT_EN).
module tb_wifi_rx_bpsk_demapper;

  logic clk = 1'b0;
  logic reset = 1'b0;

  wifi_rx_bpsk_demapper_if dif ();

  wifi_rx_bpsk_demapper #(
    .FIFO_DEPTH (64),
    .SYM_BITS   (48)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic l;
    logic b;
    int   s;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   bits_seen = 0;
  int   fin_seen = 0;
  logic prev_last = 1'b0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one sample for one cycle; push its expected decision if it will be kept.
  task automatic send(input int val, input bit last, input bit push);
    exp_t e;
    int   sh;
    dif.valid_in   = 1'b1;
    dif.data_in_re = 12'(val);
    dif.data_in_im = 12'(-val);
    dif.last_in    = last;
    if (push) begin
      e.b = (val >= 0);
      e.l = last;
      sh  = val >>> 7;
      if (sh > 7) sh = 7;
      if (sh < -8) sh = -8;
      e.s = sh;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    dif.valid_in = 1'b0;
    dif.last_in  = 1'b0;
  endtask

  task automatic drain();
    int cycles;
    cycles = 0;
    dif.re = 1'b1;
    while (exp_q.size() != 0 && cycles < 1000) begin
      @(posedge clk);
      cycles++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    dif.re = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Output monitor: compares every delivered bit against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_last = 1'b0;
      end else begin
        if (dif.valid_out) begin
          bits_seen++;
          if (exp_q.size() == 0) begin
            check_eq("unexpected_bit", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("data_out", int'(dif.data_out), int'(e.b));
            check_eq("last_sym", int'(dif.last_sym), int'(e.l));
`ifdef WIFI_RX_SOFT_OUT_EN
            check_eq("soft_out", int'($signed(dif.soft_out)), e.s);
`endif
          end
        end
        if (prev_last || dif.finished) check_eq("finished", int'(dif.finished), int'(prev_last));
        if (dif.finished) fin_seen++;
        prev_last = dif.valid_out & dif.last_sym;
      end
    end
  end

  initial begin
    int fin0;
    int bits0;
    dif.valid_in   = 1'b0;
    dif.data_in_re = '0;
    dif.data_in_im = '0;
    dif.last_in    = 1'b0;
    dif.re         = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check_eq("rst_empty", int'(dif.empty), 1);
    check_eq("rst_full", int'(dif.full), 0);
    check_eq("rst_valid_out", int'(dif.valid_out), 0);
    check_eq("rst_busy", int'(dif.busy), 0);
    check_eq("rst_overflow", int'(dif.overflow), 0);
    check_eq("rst_misalign", int'(dif.misalign), 0);
    check_eq("rst_finished", int'(dif.finished), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // 48-sample aligned frame, continuous reads
    fin0 = fin_seen;
    dif.re = 1'b1;
    for (int i = 0; i < 48; i++) send((i % 2 == 0) ? 512 : -512, i == 47, 1'b1);
    drain();
    check_eq("t1_misalign", int'(dif.misalign), 0);
    check_eq("t1_finished_count", fin_seen - fin0, 1);
    check_eq("t1_busy_after", int'(dif.busy), 0);
    do_reset();

    // 96 samples with no reads: first 64 kept, rest dropped
    for (int i = 0; i < 96; i++) send((i % 3 == 0) ? -300 : 700, i == 95, i < 64);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t2_full", int'(dif.full), 1);
    check_eq("t2_overflow", int'(dif.overflow), 1);
    check_eq("t2_empty", int'(dif.empty), 0);
    drain();
    check_eq("t2_empty_after", int'(dif.empty), 1);
    do_reset();

    // Early last -> misalign, last_sym still on bit 30
    dif.re = 1'b1;
    for (int i = 0; i < 30; i++) send((i % 2 == 0) ? 100 : -100, i == 29, 1'b1);
    drain();
    check_eq("t3_misalign", int'(dif.misalign), 1);
    do_reset();
    check_eq("t3_misalign_cleared", int'(dif.misalign), 0);

    // Edge values
    dif.re = 1'b1;
    send(0, 1'b0, 1'b1);
    send(-1, 1'b0, 1'b1);
    send(2047, 1'b0, 1'b1);
    send(-2048, 1'b1, 1'b1);
    drain();
    do_reset();

    // Full FIFO with simultaneous write and read
    for (int i = 0; i < 64; i++) send((i * 37 % 200) - 100, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t5_full_before", int'(dif.full), 1);
    send(-900, 1'b0, 1'b1);
    dif.re = 1'b1;
    @(posedge clk);
    #1;
    dif.re = 1'b0;
    check_eq("t5_full_after", int'(dif.full), 1);
    check_eq("t5_overflow", int'(dif.overflow), 0);
    drain();
    do_reset();

    // Reset mid-frame, then a clean 48-sample frame
    for (int i = 0; i < 20; i++) send(50 - i * 7, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_empty_in_reset", int'(dif.empty), 1);
    check_eq("t6_busy_in_reset", int'(dif.busy), 0);
    check_eq("t6_valid_in_reset", int'(dif.valid_out), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bits0 = bits_seen;
    dif.re = 1'b1;
    for (int i = 0; i < 48; i++) send((i % 4 < 2) ? 1500 : -1500, i == 47, 1'b1);
    drain();
    check_eq("t6_bit_count", bits_seen - bits0, 48);
    check_eq("t6_misalign", int'(dif.misalign), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
